dist_packet_reader: RTL
=======================

Name: dist_packet_reader

Overview:
- Consumer side of the distance-packet ping-pong RAM that the packet builder fills.
- On each packet-complete pulse, latches the header fields and the completed bank.
- Reads the payload bytes back out of that bank and serialises header, payload and optional checksum as a valid/ready byte stream toward the network/UART transmit path.
- Sits between the packet RAM read port and the frame transmitter.

Parameters:
- RD_LAT, 1: packet RAM read latency in clocks (1..2).
- MAX_POINTS, 250: maximum points per packet; payload = points*4 bytes, max 1000 bytes.
- BASE_ADDR, 0: first payload byte address within a bank (10-bit).
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.

Ports:
- i_clk_50m  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_packet_make  in  1  one-cycle pulse: a bank has been completed.
- i_packet_pingpang  in  1  completed bank, sampled with i_packet_make.
- i_packet_points  in  16  point count, sampled with i_packet_make.
- i_scan_counter  in  16  scan counter, sampled with i_packet_make.
- i_telegram_no  in  8  telegram number, sampled with i_packet_make.
- i_first_angle  in  16  first angle index, sampled with i_packet_make.
- o_packet_rdaddr  out  11  {bank, 10-bit byte address} to the RAM read port.
- i_packet_rddata  in  8  RAM read data, valid RD_LAT clocks after address.
- o_tx_data  out  8  output byte.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  sink accepts the byte when valid and ready are both high.
- o_tx_sof  out  1  high with the first byte (SYNC0).
- o_tx_eof  out  1  high with the last byte of the frame.
- o_busy  out  1  a frame is in progress.
- o_overrun  out  1  one-cycle pulse: a pending request was overwritten.
- o_len_error  out  1  one-cycle pulse: the point count was clamped.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; no pending request.
- Request capture:
  - On i_packet_make, the bank, points, scan, telegram and angle are stored in a one-deep pending register.
  - If a request is already pending, the new one overwrites it and o_overrun pulses.
  - A request arriving while a frame is in progress becomes pending; the current frame is not disturbed.
  - If i_packet_make coincides with the IDLE to HDR transition, the old pending request is consumed and the new one becomes pending (no overrun).
- Length:
  - pts = min(points, MAX_POINTS); if points > MAX_POINTS, o_len_error pulses once at capture.
  - Payload length in bytes = pts*4, computed in 12 bits.
- FSM states:
  - IDLE: go to HDR when a request is pending; the request is moved into the active registers; o_busy rises on the next clock.
  - HDR: emits 9 bytes in order: SYNC0, SYNC1, telegram_no, scan[15:8], scan[7:0], angle[15:8], angle[7:0], pts[15:8], pts[7:0]. Each byte is held until the handshake. Go to RD when pts>0, else to CK (or END when the checksum is compiled out).
  - RD: drive o_packet_rdaddr = {bank, BASE_ADDR+idx}; wait RD_LAT clocks.
  - CAP: register i_packet_rddata into o_tx_data; assert valid.
  - SEND: hold the byte until the handshake. Then idx+1; if idx reaches pts*4, go to CK/END, else to RD.
  - CK: emit the checksum byte.
  - END: deassert o_busy; go to IDLE.
- Handshake rules:
  - o_tx_data, o_tx_sof and o_tx_eof are stable while valid is high and ready is low.
  - Valid never drops without a handshake.
  - Back-to-back header bytes are sent at 1 byte per clock when ready is held high.
  - Payload is sent at 1 byte per RD_LAT+2 clocks.
- Address and checksum:
  - The address is 10-bit and wraps modulo 1024.
  - Bank bit = latched bank; it is never taken from the live input.
- Reset mid-frame: returns immediately to the reset state; the pending request is discarded and valid drops.

Optional Feature:
- DIST_PACKET_READER_CKSUM_EN defined:
  - A running XOR accumulates all bytes after SYNC1 (header fields plus payload).
  - One checksum byte is appended in state CK, carrying o_tx_eof.
- Not defined:
  - No CK state; o_tx_eof rides on the last payload byte, or on the pts[7:0] byte when pts=0.
  - The frame is one byte shorter.

Test Plan:
- Basic frame: pulse make with bank=1, points=3, scan=0x1234, telegram=0x07, angle=0x00A5; RAM bank1 bytes 0..11 = 0x10..0x1B; ready held high. Required stream: A5 5A 07 12 34 00 A5 00 03 10..1B, plus checksum XOR when CKSUM_EN is defined. Addresses seen are 0x400..0x40B; sof on A5, eof on the last byte.
- Backpressure: same frame with i_tx_ready toggling 1-in-3 randomly. The byte sequence must be identical, data must be stable while stalled, and no byte may be duplicated or dropped.
- Zero points: points=0. Output is the 9-byte header only (plus checksum); no RAM reads; eof on the last byte.
- Clamp: points=300. o_len_error pulses; header pts=0x00FA; exactly 1000 payload bytes; the last address is 0x3E7 (bank0).
- Overrun: three make pulses during one frame (frame, then pending, then overwrite). o_overrun pulses once; the second frame sent carries the third request's fields.
- Reset mid-payload: assert i_rst after payload byte 5. All outputs are 0 immediately; the next make produces a complete fresh frame.

Source files
------------

// File: rtl/dist_packet_reader_if.sv
`default_nettype none
// ============================================================================
//  dist_packet_reader_if
//  Packet request, packet-RAM read port and transmit byte-stream bundle for
//  the distance-packet reader.
//  master : the reader itself     slave : request source / RAM / transmitter
//  Rev 1.0  initial release
// ============================================================================
interface dist_packet_reader_if;
  logic        i_packet_make;
  logic        i_packet_pingpang;
  logic [15:0] i_packet_points;
  logic [15:0] i_scan_counter;
  logic [7:0]  i_telegram_no;
  logic [15:0] i_first_angle;
  logic [10:0] o_packet_rdaddr;
  logic [7:0]  i_packet_rddata;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_tx_sof;
  logic        o_tx_eof;
  logic        o_busy;
  logic        o_overrun;
  logic        o_len_error;

  modport master (
    input  i_packet_make, i_packet_pingpang, i_packet_points, i_scan_counter,
           i_telegram_no, i_first_angle, i_packet_rddata, i_tx_ready,
    output o_packet_rdaddr, o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof,
           o_busy, o_overrun, o_len_error
  );

  modport slave (
    output i_packet_make, i_packet_pingpang, i_packet_points, i_scan_counter,
           i_telegram_no, i_first_angle, i_packet_rddata, i_tx_ready,
    input  o_packet_rdaddr, o_tx_data, o_tx_valid, o_tx_sof, o_tx_eof,
           o_busy, o_overrun, o_len_error
  );
endinterface
`default_nettype wire

// File: rtl/dist_packet_reader.sv
`default_nettype none
// ============================================================================
//  dist_packet_reader
//  Reads a completed bank of the distance-packet ping-pong RAM and serialises
//  header + payload (+ optional XOR checksum) as a valid/ready byte stream.
//  Optional feature macro: DIST_PACKET_READER_CKSUM_EN (appends checksum byte)
//  Rev 1.0  initial release
// ============================================================================
module dist_packet_reader #(
  parameter int         RD_LAT     = 1,
  parameter int         MAX_POINTS = 250,
  parameter logic [9:0] BASE_ADDR  = 10'd0,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input wire logic             i_clk_50m,
  input wire logic             i_rst,
  dist_packet_reader_if.master bus
);

  localparam logic [15:0] MAX_PTS  = 16'(MAX_POINTS);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_SEND = 3'd4,
    S_CK   = 3'd5,
    S_END  = 3'd6
  } state_t;

`ifdef DIST_PACKET_READER_CKSUM_EN
  localparam logic   CKSUM_ON = 1'b1;
  localparam state_t DONE_ST  = S_CK;
`else
  localparam logic   CKSUM_ON = 1'b0;
  localparam state_t DONE_ST  = S_END;
`endif

  state_t      state;

  // one-deep pending request
  logic        pend_valid;
  logic        pend_bank;
  logic [15:0] pend_pts;
  logic [15:0] pend_scan;
  logic [15:0] pend_angle;
  logic [7:0]  pend_tel;
  logic        overrun_q;
  logic        len_err_q;

  // request being transmitted
  logic        act_bank;
  logic [15:0] act_pts;
  logic [15:0] act_scan;
  logic [15:0] act_angle;
  logic [7:0]  act_tel;

  logic [3:0]  hdr_idx;
  logic [11:0] idx;
  logic [1:0]  lat_cnt;
  logic [10:0] rdaddr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        sof;
  logic        eof;
  logic        busy;
`ifdef DIST_PACKET_READER_CKSUM_EN
  logic [7:0]  cks;
`endif

  logic        take;
  logic        pts_zero;
  logic [3:0]  hdr_nidx;
  logic [7:0]  hdr_byte;
  logic [11:0] len;
  logic [11:0] idx_next;
  logic        last_pl;
  logic        hs;

  // IDLE consumes the pending slot in the same clock it starts a frame
  assign take     = (state == S_IDLE) && pend_valid;
  assign pts_zero = (act_pts == 16'd0);
  assign hdr_nidx = hdr_idx + 4'd1;
  assign len      = {act_pts[9:0], 2'b00};
  assign idx_next = idx + 12'd1;
  assign last_pl  = (idx_next == len);
  assign hs       = tx_valid && bus.i_tx_ready;

  // Select the header byte that follows the one currently on the bus
  always_comb begin
    hdr_byte = act_pts[7:0];
    case (hdr_nidx)
      4'd1:    hdr_byte = SYNC1;
      4'd2:    hdr_byte = act_tel;
      4'd3:    hdr_byte = act_scan[15:8];
      4'd4:    hdr_byte = act_scan[7:0];
      4'd5:    hdr_byte = act_angle[15:8];
      4'd6:    hdr_byte = act_angle[7:0];
      4'd7:    hdr_byte = act_pts[15:8];
      default: hdr_byte = act_pts[7:0];
    endcase
  end

  // Capture requests into the pending slot; flag overwrite and clamping
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      pend_valid <= 1'b0;
      pend_bank  <= 1'b0;
      pend_pts   <= 16'd0;
      pend_scan  <= 16'd0;
      pend_angle <= 16'd0;
      pend_tel   <= 8'd0;
      overrun_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      len_err_q <= 1'b0;
      if (bus.i_packet_make) begin
        pend_valid <= 1'b1;
        pend_bank  <= bus.i_packet_pingpang;
        pend_pts   <= (bus.i_packet_points > MAX_PTS) ? MAX_PTS : bus.i_packet_points;
        pend_scan  <= bus.i_scan_counter;
        pend_angle <= bus.i_first_angle;
        pend_tel   <= bus.i_telegram_no;
        len_err_q  <= (bus.i_packet_points > MAX_PTS);
        overrun_q  <= pend_valid && !take;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Frame sequencer: header, RAM read/capture/send per payload byte, trailer
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      act_bank  <= 1'b0;
      act_pts   <= 16'd0;
      act_scan  <= 16'd0;
      act_angle <= 16'd0;
      act_tel   <= 8'd0;
      hdr_idx   <= 4'd0;
      idx       <= 12'd0;
      lat_cnt   <= 2'd0;
      rdaddr    <= 11'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
`ifdef DIST_PACKET_READER_CKSUM_EN
      cks       <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_valid) begin
            act_bank  <= pend_bank;
            act_pts   <= pend_pts;
            act_scan  <= pend_scan;
            act_angle <= pend_angle;
            act_tel   <= pend_tel;
            hdr_idx   <= 4'd0;
            idx       <= 12'd0;
            tx_data   <= SYNC0;
            tx_valid  <= 1'b1;
            sof       <= 1'b1;
            eof       <= 1'b0;
            busy      <= 1'b1;
`ifdef DIST_PACKET_READER_CKSUM_EN
            cks       <= 8'd0;
`endif
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (hs) begin
`ifdef DIST_PACKET_READER_CKSUM_EN
            // sync bytes are excluded from the checksum
            if (hdr_idx >= 4'd2) cks <= cks ^ tx_data;
`endif
            sof <= 1'b0;
            if (hdr_idx == 4'd8) begin
              tx_valid <= 1'b0;
              eof      <= 1'b0;
              if (!pts_zero) begin
                rdaddr  <= {act_bank, BASE_ADDR};
                lat_cnt <= 2'd0;
                state   <= S_RD;
              end else begin
                state <= DONE_ST;
              end
            end else begin
              hdr_idx <= hdr_nidx;
              tx_data <= hdr_byte;
              eof     <= (hdr_nidx == 4'd8) && pts_zero && !CKSUM_ON;
            end
          end
        end
        S_RD: begin
          if (lat_cnt == LAT_LAST) state <= S_CAP;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        S_CAP: begin
          tx_data  <= bus.i_packet_rddata;
          tx_valid <= 1'b1;
          eof      <= last_pl && !CKSUM_ON;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
`ifdef DIST_PACKET_READER_CKSUM_EN
            cks <= cks ^ tx_data;
`endif
            tx_valid <= 1'b0;
            eof      <= 1'b0;
            idx      <= idx_next;
            if (last_pl) begin
              state <= DONE_ST;
            end else begin
              rdaddr  <= {act_bank, BASE_ADDR + idx_next[9:0]};
              lat_cnt <= 2'd0;
              state   <= S_RD;
            end
          end
        end
`ifdef DIST_PACKET_READER_CKSUM_EN
        S_CK: begin
          if (!tx_valid) begin
            tx_data  <= cks;
            tx_valid <= 1'b1;
            eof      <= 1'b1;
          end else if (bus.i_tx_ready) begin
            tx_valid <= 1'b0;
            eof      <= 1'b0;
            state    <= S_END;
          end
        end
`endif
        S_END: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_packet_rdaddr = rdaddr;
  assign bus.o_tx_data       = tx_data;
  assign bus.o_tx_valid      = tx_valid;
  assign bus.o_tx_sof        = sof;
  assign bus.o_tx_eof        = eof;
  assign bus.o_busy          = busy;
  assign bus.o_overrun       = overrun_q;
  assign bus.o_len_error     = len_err_q;

endmodule
`default_nettype wire
